fetch_redirect_ctrl: RTL

- Sequences the fetch program counter.
- Arbitrates redirect requests from four sources: trap unit, execute (branch mispredict), decode (early redirect) and branch predictor.
- Runs the fence.i sequence: I-cache flush handshake, then resume at a saved PC.
- Drives the program counter's stall/alter/target inputs and maintains a fetch epoch so the front end can kill wrong-path fetch blocks.

---
 rtl/fetch_redirect_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: arbitrates PC redirects, runs the fence.i
// I-cache flush sequence and maintains the fetch epoch for wrong-path kill.
`timescale 1ns/1ps

module fetch_redirect_ctrl #(
  parameter int PC_WIDTH    = 32,
  parameter int EPOCH_WIDTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_trap_valid,
  input  logic [PC_WIDTH-1:0]    i_trap_pc,
  input  logic                   i_ex_redirect_valid,
  input  logic [PC_WIDTH-1:0]    i_ex_redirect_pc,
  input  logic                   i_fence_i_valid,
  input  logic [PC_WIDTH-1:0]    i_fence_i_pc,
  input  logic                   i_dec_redirect_valid,
  input  logic [PC_WIDTH-1:0]    i_dec_redirect_pc,
  input  logic                   i_bp_redirect_valid,
  input  logic [PC_WIDTH-1:0]    i_bp_redirect_pc,
  input  logic                   i_fetch_stall,
  output logic                   o_icache_flush_req,
  input  logic                   i_icache_flush_ack,
  output logic                   o_pc_stall,
  output logic                   o_pc_alter,
  output logic [PC_WIDTH-1:0]    o_pc,
  output logic [EPOCH_WIDTH-1:0] o_epoch,
  output logic                   o_flush_frontend,
  output logic                   o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    RESUME
  } state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    saved_pc_q, saved_pc_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   alter_q, alter_d;
  logic [EPOCH_WIDTH-1:0] epoch_q;

  // The epoch advances on the same edge that raises o_pc_alter, so every
  // redirected block is tagged with the new epoch from its first cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      saved_pc_q <= '0;
      pc_q       <= '0;
      alter_q    <= 1'b0;
      epoch_q    <= '0;
    end else begin
      state_q    <= state_d;
      saved_pc_q <= saved_pc_d;
      pc_q       <= pc_d;
      alter_q    <= alter_d;
      if (alter_d) begin
        epoch_q <= epoch_q + EPOCH_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    saved_pc_d = saved_pc_q;
    pc_d       = pc_q;
    alter_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_trap_valid) begin
          alter_d = 1'b1;
          pc_d    = i_trap_pc;
        end else if (i_ex_redirect_valid) begin
          alter_d = 1'b1;
          pc_d    = i_ex_redirect_pc;
        end else if (i_fence_i_valid) begin
          saved_pc_d = i_fence_i_pc;
          state_d    = FLUSH;
        end else if (i_dec_redirect_valid) begin
          alter_d = 1'b1;
          pc_d    = i_dec_redirect_pc;
        end else if (i_bp_redirect_valid) begin
          alter_d = 1'b1;
          pc_d    = i_bp_redirect_pc;
        end
      end
      FLUSH: begin
        // Only architectural redirects may replace the resume point mid-flush.
        if (i_trap_valid) begin
          saved_pc_d = i_trap_pc;
        end else if (i_ex_redirect_valid) begin
          saved_pc_d = i_ex_redirect_pc;
        end
        if (i_icache_flush_ack) begin
          state_d = RESUME;
          alter_d = 1'b1;
          pc_d    = saved_pc_d;
        end
      end
      RESUME: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_icache_flush_req = (state_q == FLUSH);
  assign o_busy             = (state_q != IDLE);
  assign o_pc_stall         = i_fetch_stall | o_busy;
  assign o_pc_alter         = alter_q;
  assign o_flush_frontend   = alter_q;
  assign o_pc               = pc_q;
  assign o_epoch            = epoch_q;

endmodule
